// File: rtl/lstm_sa_pkg.sv
// Shared types and sizing for the systolic-array address sequencer.
// ADDR_GEN_STALL_EN (optional) adds a stall input to sa_addr_gen.
package lstm_sa_pkg;

  localparam int unsigned FEATURE_BITS = 4;
  localparam int unsigned NUM_PE       = 4;
  localparam int unsigned DRAIN_W      = $clog2(NUM_PE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} addr_gen_state_t;

  typedef logic [2*FEATURE_BITS-1:0] sa_addr_t;

endpackage

// File: rtl/sa_addr_gen_if.sv
// Request/beat bundle between a tile requester and sa_addr_gen.
// ADDR_GEN_STALL_EN adds the stall_in signal.
interface sa_addr_gen_if;
  import lstm_sa_pkg::*;

  logic                    start;
  logic [FEATURE_BITS-1:0] rows_m1;
  logic [FEATURE_BITS-1:0] cols_m1;
  sa_addr_t                address_out;
  logic                    cs_out;
  logic                    enable_out;
  logic                    busy;
  logic                    done;
`ifdef ADDR_GEN_STALL_EN
  logic                    stall_in;
`endif

  modport master (
`ifdef ADDR_GEN_STALL_EN
    output stall_in,
`endif
    output start, rows_m1, cols_m1,
    input  address_out, cs_out, enable_out, busy, done
  );

  modport slave (
`ifdef ADDR_GEN_STALL_EN
    input  stall_in,
`endif
    input  start, rows_m1, cols_m1,
    output address_out, cs_out, enable_out, busy, done
  );

endinterface

// File: rtl/wrap_counter.sv
// Up-counter that wraps to zero after reaching a run-time maximum.
// wrap flags value == max so the caller can chain counters.
module wrap_counter
  import lstm_sa_pkg::*;
#(
  parameter int unsigned WIDTH = FEATURE_BITS
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  assign wrap = (value == max);

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/sa_addr_gen.sv
// Row-major tile walker feeding the delay_block chain, with drain and done pulse.
// ADDR_GEN_STALL_EN adds bus.stall_in to hold beats and freeze the drain.
module sa_addr_gen
  import lstm_sa_pkg::*;
(
  input logic          sys_clk,
  input logic          reset_n,
  sa_addr_gen_if.slave bus
);

  addr_gen_state_t         state_q, state_d;
  logic [FEATURE_BITS-1:0] rows_q, cols_q;
  logic [FEATURE_BITS-1:0] row_val, col_val;
  logic                    row_at_max, col_at_max;
  logic [DRAIN_W-1:0]      drain_q, drain_d;
  logic                    cs_q, cs_d, en_q, en_d, busy_q, busy_d, done_q, done_d;
  logic                    clr, col_inc, stall;

`ifdef ADDR_GEN_STALL_EN
  assign stall = bus.stall_in;
`else
  assign stall = 1'b0;
`endif

  wrap_counter #(.WIDTH(FEATURE_BITS)) u_col (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (col_inc),
    .max     (cols_q),
    .value   (col_val),
    .wrap    (col_at_max)
  );

  wrap_counter #(.WIDTH(FEATURE_BITS)) u_row (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (col_inc & col_at_max),
    .max     (rows_q),
    .value   (row_val),
    .wrap    (row_at_max)
  );

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cs_d    = cs_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    col_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          clr     = 1'b1;
          cs_d    = 1'b1;
          en_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stall) begin
          cs_d = 1'b0;
          en_d = 1'b0;
        end else if (!cs_q) begin
          // Previous cycle was a stall bubble: reissue the beat still held in the counters.
          cs_d = 1'b1;
          en_d = (col_val != '0);
        end else if (row_at_max && col_at_max) begin
          cs_d    = 1'b0;
          en_d    = 1'b0;
          drain_d = DRAIN_W'(NUM_PE - 1);
          state_d = DRAIN;
        end else begin
          col_inc = 1'b1;
          cs_d    = 1'b1;
          en_d    = !col_at_max;
        end
      end
      DRAIN: begin
        if (!stall) begin
          if (drain_q == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            drain_d = drain_q - 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      drain_q <= '0;
      cs_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rows_q  <= '0;
      cols_q  <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cs_q    <= cs_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (state_q == IDLE && bus.start) begin
        rows_q <= bus.rows_m1;
        cols_q <= bus.cols_m1;
      end
    end
  end

  assign bus.address_out = {row_val, col_val};
  assign bus.cs_out      = cs_q;
  assign bus.enable_out  = en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_sa_addr_gen.sv
// Self-checking bench for sa_addr_gen: per-cycle compare against a tile-level model.
// Define ADDR_GEN_STALL_EN to also exercise the stall input.
module tb_sa_addr_gen;
  import lstm_sa_pkg::*;

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;

  typedef logic [2*FEATURE_BITS+3:0] obs_t;  // {busy, done, cs, en, addr}
  obs_t exp_q[$];

  sa_addr_gen_if bus ();

  sa_addr_gen dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic obs_t observed();
    return {bus.busy, bus.done, bus.cs_out, bus.enable_out, bus.address_out};
  endfunction

  function automatic obs_t mk(logic b, logic d, logic c, logic e, int r, int col);
    logic [FEATURE_BITS-1:0] rr, cc;
    rr = FEATURE_BITS'(r);
    cc = FEATURE_BITS'(col);
    return {b, d, c, e, rr, cc};
  endfunction

  // Expected trace from the cycle after start through the first idle cycle.
  function automatic void build(int r, int c, int stall_at, int stall_len);
    int idx = 0;
    exp_q.delete();
    for (int i = 0; i <= r; i++) begin
      for (int j = 0; j <= c; j++) begin
        exp_q.push_back(mk(1, 0, 1, j != 0, i, j));
        if (idx == stall_at && stall_len > 0) begin
          for (int s = 0; s < stall_len; s++) exp_q.push_back(mk(1, 0, 0, 0, i, j));
          exp_q.push_back(mk(1, 0, 1, j != 0, i, j));
        end
        idx++;
      end
    end
    for (int k = 0; k < int'(NUM_PE); k++) exp_q.push_back(mk(1, 0, 0, 0, r, c));
    exp_q.push_back(mk(0, 1, 0, 0, r, c));
    exp_q.push_back(mk(0, 0, 0, 0, r, c));
  endfunction

  task automatic set_stall(logic v);
`ifdef ADDR_GEN_STALL_EN
    bus.stall_in = v;
`else
    if (v) $display("note: stall requested in a build without stall support");
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle.
  task automatic run_tile(string name, int r, int c, bit junk, int stall_at, int stall_len);
    obs_t got;
    build(r, c, stall_at, stall_len);
    bus.start   = 1'b1;
    bus.rows_m1 = FEATURE_BITS'(r);
    bus.cols_m1 = FEATURE_BITS'(c);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge sys_clk);
      got = observed();
      n_vec++;
      if (got !== exp_q[k]) begin
        n_err++;
        $display("FAIL %s cycle %0d: got busy/done/cs/en/addr=%b_%b_%b_%b_%h want %b_%b_%b_%b_%h",
                 name, k, got[11], got[10], got[9], got[8], got[7:0],
                 exp_q[k][11], exp_q[k][10], exp_q[k][9], exp_q[k][8], exp_q[k][7:0]);
      end
      if (junk && k < exp_q.size() - 1) begin
        bus.start   = 1'($urandom);
        bus.rows_m1 = FEATURE_BITS'($urandom);
        bus.cols_m1 = FEATURE_BITS'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      set_stall(stall_len > 0 && k >= stall_at && k < stall_at + stall_len);
    end
    bus.start = 1'b0;
  endtask

  task automatic check_idle(string name, int cycles);
    obs_t got;
    for (int k = 0; k < cycles; k++) begin
      @(negedge sys_clk);
      got = observed();
      n_vec++;
      if (got[11:8] !== 4'b0000) begin
        n_err++;
        $display("FAIL %s cycle %0d: got busy/done/cs/en=%b want 0000", name, k, got[11:8]);
      end
    end
  endtask

  task automatic test_reset();
    obs_t got;
    bus.start   = 1'b0;
    bus.rows_m1 = '0;
    bus.cols_m1 = '0;
    set_stall(1'b0);
    reset_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    reset_n = 1'b1;
    got = observed();
    n_vec++;
    if (got !== '0) begin
      n_err++;
      $display("FAIL reset_init: got %h want 000", got);
    end
    // Abort a 4x4 tile mid-RUN.
    bus.start   = 1'b1;
    bus.rows_m1 = 4'd3;
    bus.cols_m1 = 4'd3;
    @(negedge sys_clk);
    bus.start = 1'b0;
    repeat (4) @(negedge sys_clk);
    reset_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    reset_n = 1'b1;
    got = observed();
    n_vec++;
    if (got !== '0) begin
      n_err++;
      $display("FAIL reset_mid_run: got %h want 000", got);
    end
    check_idle("reset_no_done", 8);
  endtask

  task automatic test_tile_2x3();
    run_tile("tile_2x3", 1, 2, 1'b0, -1, 0);
  endtask

  task automatic test_tile_1x1();
    run_tile("tile_1x1", 0, 0, 1'b0, -1, 0);
  endtask

  task automatic test_ignored_starts();
    run_tile("ignored_starts", 2, 3, 1'b1, -1, 0);
  endtask

  task automatic test_back_to_back();
    run_tile("b2b_first", 0, 1, 1'b0, -1, 0);
    run_tile("b2b_second", 1, 0, 1'b0, -1, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      run_tile("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b1, -1, 0);
    end
  endtask

`ifdef ADDR_GEN_STALL_EN
  task automatic test_stall();
    run_tile("stall_beat02", 0, 3, 1'b0, 2, 2);
    run_tile("stall_random", 1, 2, 1'b1, int'($urandom_range(0, 5)),
             int'($urandom_range(1, 3)));
  endtask
`endif

  initial begin
    test_reset();
    test_tile_2x3();
    test_tile_1x1();
    test_ignored_starts();
    test_back_to_back();
    test_random();
`ifdef ADDR_GEN_STALL_EN
    test_stall();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
